// File: rtl/ubs_pkg.sv
// rtl/ubs_pkg.sv - shared defaults, width helper and lane-count clamp for the un-striper
package ubs_pkg;

  localparam int UBS_W     = 8;
  localparam int UBS_LANES = 4;
  localparam int UBS_DEPTH = 4;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } ubs_state_t;

  function automatic int ubs_clog2(input int v);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= v) return r;
    end
    return 31;
  endfunction

  // Zero or an over-range request falls back to the full physical width.
  function automatic int ubs_clamp_lanes(input int req, input int lanes);
    return ((req == 0) || (req > lanes)) ? lanes : req;
  endfunction

endpackage

// File: rtl/ubs_lane_fifo.sv
// rtl/ubs_lane_fifo.sv - per-lane elastic FIFO with combinational head
module ubs_lane_fifo
  import ubs_pkg::*;
#(
  parameter int W     = UBS_W,
  parameter int DEPTH = UBS_DEPTH
) (
  input  logic         clk_f,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = ubs_clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign dout   = r_mem[r_rptr];
  // A full FIFO refuses the write even when it is popped in the same cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk_f) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk_f) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/byte_unstriping_nlane.sv
// rtl/byte_unstriping_nlane.sv - N-lane round-robin byte un-striper with valid/ready output
module byte_unstriping_nlane
  import ubs_pkg::*;
#(
  parameter int W     = UBS_W,
  parameter int LANES = UBS_LANES,
  parameter int DEPTH = UBS_DEPTH
) (
  input  logic                              clk_f,
  input  logic                              reset,
  input  logic [LANES*W-1:0]                lane_data,
  input  logic [LANES-1:0]                  lane_valid,
  output logic [LANES-1:0]                  lane_ready,
  input  logic [ubs_clog2(LANES+1)-1:0]     active_lanes,
  output logic [W-1:0]                      data_out,
  output logic                              valid_out,
  input  logic                              ready_out,
  output logic                              overflow
);

  localparam int CW = ubs_clog2(LANES+1);
  localparam int RW = ubs_clog2(LANES);

  logic [LANES-1:0] w_full;
  logic [LANES-1:0] w_empty;
  logic [LANES-1:0] w_push;
  logic [LANES-1:0] w_pop;
  logic [LANES-1:0] w_active;
  logic [W-1:0]     w_head [LANES];

  logic [RW-1:0] r_rr;
  logic [CW-1:0] r_cfg_lanes;
  logic [W-1:0]  r_data;
  logic          r_valid;
  logic          r_overflow;

  logic          w_out_free;
  logic          w_load;
  logic [CW-1:0] w_rr_inc;
  logic [RW-1:0] w_rr_nxt;
  logic          w_drop_active;
  ubs_state_t    w_state;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_active[gi]   = (CW'(gi) < r_cfg_lanes);
      assign lane_ready[gi] = !w_full[gi] && w_active[gi];
      assign w_push[gi]     = lane_valid[gi] && lane_ready[gi];
      assign w_pop[gi]      = w_load && (r_rr == RW'(gi));

      ubs_lane_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk_f (clk_f),
        .reset (reset),
        .push  (w_push[gi]),
        .pop   (w_pop[gi]),
        .din   (lane_data[gi*W +: W]),
        .dout  (w_head[gi]),
        .full  (w_full[gi]),
        .empty (w_empty[gi])
      );
    end
  endgenerate

  // Strict order: only the lane under rr may feed the output, even if others hold data.
  always_comb begin
    w_out_free    = !r_valid || ready_out;
    w_load        = w_out_free && !w_empty[r_rr];
    w_rr_inc      = CW'(r_rr) + 1'b1;
    w_rr_nxt      = (w_rr_inc >= r_cfg_lanes) ? '0 : r_rr + 1'b1;
    w_drop_active = |(lane_valid & w_full & w_active);
    w_state       = ((&w_empty) && (r_rr == '0)) ? ST_IDLE : ST_STREAM;
  end

  always_ff @(posedge clk_f) begin
    if (!reset) begin
      r_rr        <= '0;
      r_cfg_lanes <= CW'(LANES);
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= w_head[r_rr];
        r_valid <= 1'b1;
        r_rr    <= w_rr_nxt;
      end else if (r_valid && ready_out) begin
        r_valid <= 1'b0;
      end
      // Lane count only changes between streams so no round is split across widths.
      if ((w_state == ST_IDLE) && w_out_free)
        r_cfg_lanes <= CW'(ubs_clamp_lanes(int'(active_lanes), LANES));
      if (w_drop_active) r_overflow <= 1'b1;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_byte_unstriping_nlane.sv
// tb/tb_byte_unstriping_nlane.sv - scoreboard bench for the N-lane un-striper
module tb_byte_unstriping_nlane;

  localparam int W     = 8;
  localparam int LANES = 4;
  localparam int DEPTH = 4;

  logic             clk_f = 1'b0;
  logic             reset = 1'b0;
  logic [LANES*W-1:0] lane_data = '0;
  logic [LANES-1:0] lane_valid = '0;
  logic [LANES-1:0] lane_ready;
  logic [2:0]       active_lanes = 3'd4;
  logic [W-1:0]     data_out;
  logic             valid_out;
  logic             ready_out = 1'b1;
  logic             overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_b;

  byte_unstriping_nlane #(.W(W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk_f        (clk_f),
    .reset        (reset),
    .lane_data    (lane_data),
    .lane_valid   (lane_valid),
    .lane_ready   (lane_ready),
    .active_lanes (active_lanes),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .overflow     (overflow)
  );

  always #5 clk_f = ~clk_f;

  // Scoreboard: every accepted output byte must match the next expected byte.
  always @(negedge clk_f) begin
    if (reset && valid_out && ready_out) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_extra: got %02h, expected no byte", data_out);
      end else begin
        exp_b = exp_q.pop_front();
        if (data_out !== exp_b)
          $display("FAIL scoreboard_data: got %02h, expected %02h", data_out, exp_b);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  task automatic drive_round(input logic [LANES-1:0] v, input logic [W-1:0] base);
    lane_valid = v;
    for (int i = 0; i < LANES; i++) lane_data[i*W +: W] = base + W'(i);
  endtask

  task automatic drain();
    lane_valid = '0;
    ready_out  = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick();
    tick();
    tick();
    n_checks++;
    if (exp_q.size() != 0 || valid_out !== 1'b0)
      $display("FAIL drain: left %0d bytes, valid_out=%b, expected 0 bytes and 0", exp_q.size(), valid_out);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    n_checks++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || overflow !== 1'b0)
      $display("FAIL reset_outputs: valid=%b data=%02h ovf=%b, expected 0 00 0", valid_out, data_out, overflow);
    else n_pass++;
    n_checks++;
    if (lane_ready !== 4'b1111) $display("FAIL reset_ready: got %b, expected 1111", lane_ready);
    else n_pass++;
  endtask

  task automatic test_aligned();
    drive_round(4'b1111, 8'h00);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
    tick();
    n_checks++;
    if (valid_out !== 1'b0) $display("FAIL aligned_latency: valid_out=%b, expected 0", valid_out);
    else n_pass++;
    drive_round(4'b1111, 8'h04);
    for (int i = 4; i < 8; i++) exp_q.push_back(8'(i));
    tick();
    lane_valid = '0;
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h00)
      $display("FAIL aligned_first: valid=%b data=%02h, expected 1 00", valid_out, data_out);
    else n_pass++;
    for (int k = 0; k < 7; k++) begin
      tick();
      n_checks++;
      if (valid_out !== 1'b1) $display("FAIL aligned_throughput: cycle %0d valid_out=%b, expected 1", k, valid_out);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_skew();
    drive_round(4'b1011, 8'h10);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
    tick();
    lane_valid = '0;
    tick();
    tick();
    drive_round(4'b0100, 8'h10);
    tick();
    lane_valid = '0;
    n_checks++;
    if (valid_out !== 1'b0) $display("FAIL skew_stall: valid_out=%b, expected 0", valid_out);
    else n_pass++;
    tick();
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h12)
      $display("FAIL skew_resume: valid=%b data=%02h, expected 1 12", valid_out, data_out);
    else n_pass++;
    drain();
  endtask

  task automatic test_backpressure();
    ready_out = 1'b0;
    for (int r = 0; r < 6; r++) begin
      drive_round(4'b1111, 8'h40 + 8'(4*r));
      for (int i = 0; i < LANES; i++)
        if (r < 4 || (r == 4 && i == 0)) exp_q.push_back(8'h40 + 8'(4*r + i));
      if (r == 4) begin
        n_checks++;
        if (lane_ready !== 4'b0001 || overflow !== 1'b0)
          $display("FAIL bp_fill: ready=%b ovf=%b, expected 0001 0", lane_ready, overflow);
        else n_pass++;
      end
      tick();
      if (r >= 1) begin
        n_checks++;
        if (valid_out !== 1'b1 || data_out !== 8'h40)
          $display("FAIL bp_hold: valid=%b data=%02h, expected 1 40", valid_out, data_out);
        else n_pass++;
      end
    end
    n_checks++;
    if (lane_ready !== 4'b0000 || overflow !== 1'b1)
      $display("FAIL bp_full: ready=%b ovf=%b, expected 0000 1", lane_ready, overflow);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_midstream();
    ready_out = 1'b0;
    drive_round(4'b1111, 8'hA0);
    tick();
    drive_round(4'b0001, 8'hB0);
    tick();
    lane_valid = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    n_checks++;
    if (valid_out !== 1'b0 || overflow !== 1'b0 || lane_ready !== 4'b1111)
      $display("FAIL midreset: valid=%b ovf=%b ready=%b, expected 0 0 1111", valid_out, overflow, lane_ready);
    else n_pass++;
    ready_out = 1'b1;
    drive_round(4'b1111, 8'h60);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h60 + 8'(i));
    tick();
    lane_valid = '0;
    tick();
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h60)
      $display("FAIL midreset_restart: valid=%b data=%02h, expected 1 60", valid_out, data_out);
    else n_pass++;
    drain();
  endtask

  task automatic test_degraded();
    active_lanes = 3'd2;
    tick();
    n_checks++;
    if (lane_ready !== 4'b0011) $display("FAIL degraded_ready: got %b, expected 0011", lane_ready);
    else n_pass++;
    drive_round(4'b1111, 8'h70);
    exp_q.push_back(8'h70);
    exp_q.push_back(8'h71);
    tick();
    active_lanes = 3'd4;
    drive_round(4'b1111, 8'h72);
    exp_q.push_back(8'h72);
    exp_q.push_back(8'h73);
    tick();
    n_checks++;
    if (lane_ready !== 4'b0011 || overflow !== 1'b0)
      $display("FAIL degraded_midchange: ready=%b ovf=%b, expected 0011 0", lane_ready, overflow);
    else n_pass++;
    drain();
    n_checks++;
    if (lane_ready !== 4'b1111) $display("FAIL degraded_idle_reload: got %b, expected 1111", lane_ready);
    else n_pass++;
    active_lanes = 3'd2;
    tick();
    active_lanes = 3'd7;
    tick();
    n_checks++;
    if (lane_ready !== 4'b1111) $display("FAIL degraded_clamp: got %b, expected 1111", lane_ready);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_skew();
    test_backpressure();
    test_reset_midstream();
    test_degraded();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
